// File: rtl/lake_config_sequencer.sv
// Configuration and run sequencer for a lakespec memory instance.
// Config words land in a shadow register and are committed atomically to
// config_memory. A commit then drives the flush/stall bring-up and counts
// run cycles up to a programmed limit.
module lake_config_sequencer #(
    parameter int CONFIG_MEMORY_SIZE = 512,
    parameter int CFG_WIDTH          = 32,
    parameter int FLUSH_CYCLES       = 4,
    localparam int NUM_WORDS = (CONFIG_MEMORY_SIZE + CFG_WIDTH - 1) / CFG_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          config_write,
    input  logic                          config_read,
    input  logic [31:0]                   config_addr,
    input  logic [CFG_WIDTH-1:0]          config_data,
    output logic [CFG_WIDTH-1:0]          config_rdata,
    output logic                          config_rvalid,
    input  logic                          commit,
    input  logic                          abort,
    input  logic [31:0]                   run_cycles,
    output logic [CONFIG_MEMORY_SIZE-1:0] config_memory,
    output logic                          flush,
    output logic                          stall,
    output logic                          done,
    output logic                          err,
    output logic [63:0]                   cycle_count
);

    localparam int SHADOW_W  = NUM_WORDS * CFG_WIDTH;
    localparam int LAST_BITS = CONFIG_MEMORY_SIZE - CFG_WIDTH * (NUM_WORDS - 1);
    // Bits of the last word that exist in config_memory; the rest stay 0
    // in the shadow so reads of dropped bits return 0.
    localparam logic [CFG_WIDTH-1:0] LAST_MASK = {CFG_WIDTH{1'b1}} >> (CFG_WIDTH - LAST_BITS);
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, FLUSH, RUN, DONE} state_t;

    state_t                          state, state_next;
    logic [SHADOW_W-1:0]             shadow, shadow_next;
    logic [CONFIG_MEMORY_SIZE-1:0]   config_memory_next;
    logic                            flush_next, stall_next, done_next, err_next;
    logic [63:0]                     cycle_count_next;
    logic [CFG_WIDTH-1:0]            config_rdata_next;
    logic                            config_rvalid_next;
    logic [FCW-1:0]                  flush_cnt, flush_cnt_next;
    logic [31:0]                     run_limit, run_limit_next;
    logic                            write_allowed, addr_in_range;

    // Next-state, shadow update, read path and error tracking.
    always_comb begin
        state_next         = state;
        shadow_next        = shadow;
        config_memory_next = config_memory;
        flush_next         = flush;
        stall_next         = stall;
        done_next          = done;
        err_next           = err;
        cycle_count_next   = cycle_count;
        config_rdata_next  = config_rdata;
        config_rvalid_next = config_read;
        flush_cnt_next     = flush_cnt;
        run_limit_next     = run_limit;

        write_allowed = (state == IDLE) || (state == DONE);
        addr_in_range = config_addr < 32'(NUM_WORDS);

        for (int w = 0; w < NUM_WORDS; w++) begin
            if (config_write && write_allowed && config_addr == 32'(w)) begin
                shadow_next[w*CFG_WIDTH +: CFG_WIDTH] =
                    config_data & ((w == NUM_WORDS - 1) ? LAST_MASK : {CFG_WIDTH{1'b1}});
            end
        end

        if (config_read) begin
            config_rdata_next = '0;
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (config_addr == 32'(w)) begin
                    config_rdata_next = shadow[w*CFG_WIDTH +: CFG_WIDTH];
                end
            end
        end

        case (state)
            IDLE, DONE: begin
                if (state == DONE && abort) begin
                    state_next = IDLE;
                    flush_next = 1'b0;
                    stall_next = 1'b1;
                    done_next  = 1'b0;
                end else if (commit) begin
                    config_memory_next = shadow_next[CONFIG_MEMORY_SIZE-1:0];
                    err_next           = 1'b0;
                    cycle_count_next   = '0;
                    done_next          = 1'b0;
                    flush_next         = 1'b1;
                    stall_next         = 1'b1;
                    flush_cnt_next     = '0;
                    run_limit_next     = run_cycles;
                    state_next         = FLUSH;
                end
            end
            FLUSH: begin
                if (abort) begin
                    state_next = IDLE;
                    flush_next = 1'b0;
                    stall_next = 1'b1;
                    done_next  = 1'b0;
                end else if (flush_cnt == FLUSH_LAST) begin
                    flush_next = 1'b0;
                    stall_next = 1'b0;
                    state_next = RUN;
                end else begin
                    flush_cnt_next = flush_cnt + 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                    flush_next = 1'b0;
                    stall_next = 1'b1;
                    done_next  = 1'b0;
                end else begin
                    cycle_count_next = cycle_count + 64'd1;
                    if (run_limit != 32'd0 && cycle_count + 64'd1 == {32'd0, run_limit}) begin
                        stall_next = 1'b1;
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if ((config_write && (!write_allowed || !addr_in_range)) ||
            (config_read && !addr_in_range)) begin
            err_next = 1'b1;
        end
    end

    // State and output registers, all cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shadow        <= '0;
            config_memory <= '0;
            flush         <= 1'b0;
            stall         <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            cycle_count   <= '0;
            config_rdata  <= '0;
            config_rvalid <= 1'b0;
            flush_cnt     <= '0;
            run_limit     <= '0;
        end else begin
            state         <= state_next;
            shadow        <= shadow_next;
            config_memory <= config_memory_next;
            flush         <= flush_next;
            stall         <= stall_next;
            done          <= done_next;
            err           <= err_next;
            cycle_count   <= cycle_count_next;
            config_rdata  <= config_rdata_next;
            config_rvalid <= config_rvalid_next;
            flush_cnt     <= flush_cnt_next;
            run_limit     <= run_limit_next;
        end
    end

endmodule
